// File: rtl/ccip_line_rd_engine.sv
// CCI-P c0 line read engine: issues tagged reads for a block of cache lines and
// reorders the responses so lines leave on a valid/ready stream in address order.
module ccip_line_rd_engine #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 42,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_lines,
  output logic              busy,
  output logic              done,
  output logic              c0_req_valid,
  output logic [ADDR_W-1:0] c0_req_addr,
  output logic [15:0]       c0_req_mdata,
  input  logic              c0_alm_full,
  input  logic              c0_rsp_valid,
  input  logic [15:0]       c0_rsp_mdata,
  input  logic [511:0]      c0_rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [511:0]      out_data,
  output logic              out_last
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  issued;
  logic [CNT_W-1:0]  emitted;
  logic [CNT_W-1:0]  outstanding;
  logic [IDX_W-1:0]  wr_ptr;
  logic [IDX_W-1:0]  rd_ptr;
  logic [IDX_W-1:0]  rsp_idx;
  logic              issue_ok;
  logic              rsp_accept;
  logic              emit;

  logic [DEPTH-1:0]  slot_valid;
  logic [511:0]      slot_data [DEPTH];

  logic              unused_rsp_tag_bits;

  // Tags carry only the slot index; the upper mdata bits are always zero.
  assign unused_rsp_tag_bits = ^c0_rsp_mdata[15:IDX_W];

  assign outstanding = issued - emitted;
  assign rsp_idx     = c0_rsp_mdata[IDX_W-1:0];
  assign issue_ok    = (state == ST_ISSUE) && (issued < num_q) &&
                       (outstanding < CNT_W'(DEPTH)) && !c0_alm_full;
  assign rsp_accept  = c0_rsp_valid && ((state == ST_ISSUE) || (state == ST_DRAIN));
  assign emit        = out_valid && out_ready;

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign out_valid = slot_valid[rd_ptr];
  assign out_data  = slot_data[rd_ptr];
  assign out_last  = (emitted == (num_q - CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      base_q       <= '0;
      num_q        <= '0;
      issued       <= '0;
      emitted      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      c0_req_valid <= 1'b0;
      c0_req_addr  <= '0;
      c0_req_mdata <= '0;
    end else begin
      c0_req_valid <= issue_ok;
      if (issue_ok) begin
        c0_req_addr  <= base_q + ADDR_W'(issued);
        c0_req_mdata <= {{(16-IDX_W){1'b0}}, wr_ptr};
        wr_ptr       <= wr_ptr + IDX_W'(1);
        issued       <= issued + CNT_W'(1);
      end
      if (emit) begin
        rd_ptr  <= rd_ptr + IDX_W'(1);
        emitted <= emitted + CNT_W'(1);
      end

      // Job bookkeeping restarts on every accepted start so tags begin at slot 0.
      case (state)
        ST_IDLE: begin
          if (start) begin
            base_q  <= base_addr;
            num_q   <= num_lines;
            issued  <= '0;
            emitted <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            state   <= (num_lines == '0) ? ST_DONE : ST_ISSUE;
          end
        end
        ST_ISSUE: if (issued == num_q)  state <= ST_DRAIN;
        ST_DRAIN: if (emitted == num_q) state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // A slot is re-tagged only after emission, so set and clear never target the same slot.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_valid[i] <= 1'b0;
        slot_data[i]  <= '0;
      end
    end else begin
      if (rsp_accept) begin
        slot_valid[rsp_idx] <= 1'b1;
        slot_data[rsp_idx]  <= c0_rsp_data;
      end
      if (emit) slot_valid[rd_ptr] <= 1'b0;
    end
  end

  a_no_double_fill: assert property (@(posedge clk) disable iff (!reset_n)
    rsp_accept |-> !slot_valid[rsp_idx]);

endmodule

// File: tb/tb_ccip_line_rd_engine.sv
// Directed bench for ccip_line_rd_engine: hand-computed request, reorder and
// handshake expectations checked with immediate assertions.
module tb_ccip_line_rd_engine;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [41:0]   base_addr;
  logic [15:0]   num_lines;
  logic          busy;
  logic          done;
  logic          c0_req_valid;
  logic [41:0]   c0_req_addr;
  logic [15:0]   c0_req_mdata;
  logic          c0_alm_full;
  logic          c0_rsp_valid;
  logic [15:0]   c0_rsp_mdata;
  logic [511:0]  c0_rsp_data;
  logic          out_valid;
  logic          out_ready;
  logic [511:0]  out_data;
  logic          out_last;

  int compared   = 0;
  int mismatched = 0;
  int cyc_count  = 0;
  int done_cnt   = 0;
  int start_cycle;

  logic [41:0]  req_addr_q[$];
  logic [15:0]  req_mdata_q[$];
  int           req_cyc_q[$];
  logic [511:0] out_data_q[$];
  logic         out_last_q[$];

  ccip_line_rd_engine dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .base_addr    (base_addr),
    .num_lines    (num_lines),
    .busy         (busy),
    .done         (done),
    .c0_req_valid (c0_req_valid),
    .c0_req_addr  (c0_req_addr),
    .c0_req_mdata (c0_req_mdata),
    .c0_alm_full  (c0_alm_full),
    .c0_rsp_valid (c0_rsp_valid),
    .c0_rsp_mdata (c0_rsp_mdata),
    .c0_rsp_data  (c0_rsp_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_count <= cyc_count + 1;

  // Inputs change 1 time unit after posedge, so negedge samples match the next edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (c0_req_valid) begin
        req_addr_q.push_back(c0_req_addr);
        req_mdata_q.push_back(c0_req_mdata);
        req_cyc_q.push_back(cyc_count);
      end
      if (out_valid && out_ready) begin
        out_data_q.push_back(out_data);
        out_last_q.push_back(out_last);
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [511:0] line_data(logic [41:0] a);
    return {8{22'h15A5A5, a}};
  endfunction

  function automatic logic [41:0] req_addr_at(int k);
    return (k < req_addr_q.size()) ? req_addr_q[k] : 42'hx;
  endfunction

  function automatic logic [15:0] req_mdata_at(int k);
    return (k < req_mdata_q.size()) ? req_mdata_q[k] : 16'hx;
  endfunction

  function automatic int req_cyc_at(int k);
    return (k < req_cyc_q.size()) ? req_cyc_q[k] : -1000;
  endfunction

  function automatic logic [511:0] out_data_at(int k);
    return (k < out_data_q.size()) ? out_data_q[k] : 512'hx;
  endfunction

  function automatic logic out_last_at(int k);
    return (k < out_last_q.size()) ? out_last_q[k] : 1'bx;
  endfunction

  task automatic check_output(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    req_addr_q.delete();
    req_mdata_q.delete();
    req_cyc_q.delete();
    out_data_q.delete();
    out_last_q.delete();
    done_cnt = 0;
  endtask

  task automatic apply_stimulus(input logic [41:0] base, input logic [15:0] num);
    start       = 1'b1;
    base_addr   = base;
    num_lines   = num;
    start_cycle = cyc_count;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic send_rsp(input logic [15:0] tag, input logic [511:0] data);
    c0_rsp_valid = 1'b1;
    c0_rsp_mdata = tag;
    c0_rsp_data  = data;
    cyc(1);
    c0_rsp_valid = 1'b0;
  endtask

  task automatic wait_reqs(input int n, input string tag);
    for (int i = 0; i < 100 && req_addr_q.size() < n; i++) cyc(1);
    check_output(tag, req_addr_q.size(), n);
  endtask

  task automatic wait_done(input int n, input string tag);
    for (int i = 0; i < 300 && done_cnt < n; i++) cyc(1);
    check_output(tag, done_cnt, n);
  endtask

  initial begin
    reset_n      = 1'b0;
    start        = 1'b0;
    base_addr    = '0;
    num_lines    = '0;
    c0_alm_full  = 1'b0;
    c0_rsp_valid = 1'b0;
    c0_rsp_mdata = '0;
    c0_rsp_data  = '0;
    out_ready    = 1'b1;
    cyc(3);
    @(negedge clk);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_req_valid", c0_req_valid, 0);
    check_output("rst_req_addr", c0_req_addr, 0);
    check_output("rst_req_mdata", c0_req_mdata, 0);
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_out_data", out_data, 0);
    check_output("rst_out_last", out_last, 0);
    cyc(1);
    reset_n = 1'b1;
    cyc(2);

    $display("[TB] job 1: 4 lines in order");
    clear_logs();
    apply_stimulus(42'h1000, 16'd4);
    check_output("j1_busy", busy, 1);
    wait_reqs(4, "j1_req_count");
    for (int i = 0; i < 4; i++) begin
      check_output("j1_req_addr", req_addr_at(i), 42'h1000 + 42'(i));
      check_output("j1_req_mdata", req_mdata_at(i), 16'(i));
    end
    check_output("j1_first_req_latency", req_cyc_at(0) - start_cycle, 2);
    for (int i = 0; i < 4; i++) send_rsp(16'(i), line_data(42'h1000 + 42'(i)));
    wait_done(1, "j1_done");
    cyc(3);
    check_output("j1_done_pulses", done_cnt, 1);
    check_output("j1_out_count", out_data_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check_output("j1_out_data", out_data_at(i), line_data(42'h1000 + 42'(i)));
      check_output("j1_out_last", out_last_at(i), (i == 3) ? 1'b1 : 1'b0);
    end
    check_output("j1_idle_busy", busy, 0);

    $display("[TB] job 2: responses 3,1,0,2");
    clear_logs();
    apply_stimulus(42'h1000, 16'd4);
    wait_reqs(4, "j2_req_count");
    check_output("j2_req_mdata0", req_mdata_at(0), 16'd0);
    send_rsp(16'd3, line_data(42'h1003));
    send_rsp(16'd1, line_data(42'h1001));
    @(negedge clk);
    check_output("j2_no_out_before_tag0", out_valid, 0);
    cyc(1);
    c0_rsp_valid = 1'b1;
    c0_rsp_mdata = 16'd0;
    c0_rsp_data  = line_data(42'h1000);
    @(negedge clk);
    check_output("j2_out_valid_same_cycle", out_valid, 0);
    cyc(1);
    c0_rsp_valid = 1'b0;
    @(negedge clk);
    check_output("j2_out_valid_next_cycle", out_valid, 1);
    check_output("j2_out_data_next_cycle", out_data, line_data(42'h1000));
    cyc(3);
    send_rsp(16'd2, line_data(42'h1002));
    wait_done(1, "j2_done");
    check_output("j2_out_count", out_data_q.size(), 4);
    for (int i = 0; i < 4; i++)
      check_output("j2_out_order", out_data_at(i), line_data(42'h1000 + 42'(i)));
    check_output("j2_out_last", out_last_at(3), 1);

    $display("[TB] job 3: 20 lines, depth limit, then mid-job reset");
    clear_logs();
    apply_stimulus(42'h2000, 16'd20);
    cyc(30);
    check_output("j3_req_count_full", req_addr_q.size(), 8);
    check_output("j3_req_valid_held_low", c0_req_valid, 0);
    check_output("j3_req_addr7", req_addr_at(7), 42'h2007);
    check_output("j3_req_mdata7", req_mdata_at(7), 16'd7);
    send_rsp(16'd0, line_data(42'h2000));
    cyc(6);
    check_output("j3_req_count_after_emit", req_addr_q.size(), 9);
    check_output("j3_req_addr8", req_addr_at(8), 42'h2008);
    check_output("j3_req_mdata8", req_mdata_at(8), 16'd0);
    check_output("j3_out_data0", out_data_at(0), line_data(42'h2000));
    reset_n = 1'b0;
    cyc(2);
    check_output("j3_reset_busy", busy, 0);
    check_output("j3_reset_req_valid", c0_req_valid, 0);
    reset_n = 1'b1;
    cyc(1);
    send_rsp(16'd0, line_data(42'h2000));
    cyc(2);
    check_output("j3_stale_rsp_dropped", out_valid, 0);
    check_output("j3_stale_no_done", done_cnt, 0);

    $display("[TB] job 4: almost-full stall");
    clear_logs();
    apply_stimulus(42'h3000, 16'd6);
    cyc(1);
    c0_alm_full = 1'b1;
    cyc(5);
    c0_alm_full = 1'b0;
    wait_reqs(6, "j4_req_count");
    check_output("j4_req0_cycle", req_cyc_at(0) - start_cycle, 2);
    check_output("j4_req1_cycle", req_cyc_at(1) - start_cycle, 8);
    check_output("j4_req2_cycle", req_cyc_at(2) - start_cycle, 9);
    check_output("j4_req1_addr", req_addr_at(1), 42'h3001);
    for (int i = 0; i < 6; i++) send_rsp(16'(i), line_data(42'h3000 + 42'(i)));
    wait_done(1, "j4_done");
    check_output("j4_out_count", out_data_q.size(), 6);
    check_output("j4_out_data5", out_data_at(5), line_data(42'h3005));

    $display("[TB] job 5: downstream stall with 3 lines buffered");
    clear_logs();
    out_ready = 1'b0;
    apply_stimulus(42'h4000, 16'd3);
    wait_reqs(3, "j5_req_count");
    for (int i = 0; i < 3; i++) send_rsp(16'(i), line_data(42'h4000 + 42'(i)));
    apply_stimulus(42'h9000, 16'd7);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_output("j5_stall_valid", out_valid, 1);
      check_output("j5_stall_data", out_data, line_data(42'h4000));
      cyc(1);
    end
    check_output("j5_start_ignored", req_addr_q.size(), 3);
    out_ready = 1'b1;
    wait_done(1, "j5_done");
    check_output("j5_out_count", out_data_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check_output("j5_out_order", out_data_at(i), line_data(42'h4000 + 42'(i)));
      check_output("j5_out_last", out_last_at(i), (i == 2) ? 1'b1 : 1'b0);
    end

    $display("[TB] job 6: zero lines");
    clear_logs();
    apply_stimulus(42'h5000, 16'd0);
    wait_done(1, "j6_done");
    cyc(3);
    check_output("j6_done_pulses", done_cnt, 1);
    check_output("j6_no_reqs", req_addr_q.size(), 0);
    check_output("j6_no_out", out_data_q.size(), 0);

    $display("[TB] job 7: address wrap");
    clear_logs();
    apply_stimulus(42'h3FF_FFFF_FFFF, 16'd2);
    wait_reqs(2, "j7_req_count");
    check_output("j7_req_addr0", req_addr_at(0), 42'h3FF_FFFF_FFFF);
    check_output("j7_req_addr1", req_addr_at(1), 42'h0);
    send_rsp(16'd0, line_data(42'h3FF_FFFF_FFFF));
    send_rsp(16'd1, line_data(42'h0));
    wait_done(1, "j7_done");
    check_output("j7_out_data1", out_data_at(1), line_data(42'h0));
    check_output("j7_out_last1", out_last_at(1), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
